// File: rtl/btn_debounce_latch.sv
// Four debounced push-buttons; each debounced press latches its 4-bit slide-switch group into the LEDs.
// All raw inputs are double-synchronized, and every output comes straight from a register.
module btn_debounce_latch #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btn,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic [3:0]  btn_stable,
  output logic [3:0]  press_pulse
);

  localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       r_btn_sync1;
  logic [3:0]       r_btn_sync2;
  logic [15:0]      r_sw_sync1;
  logic [15:0]      r_sw_sync2;
  logic [CNT_W-1:0] r_cnt [4];
  logic [3:0]       r_btn_stable;
  logic [3:0]       r_press_pulse;
  logic [15:0]      r_led;

  logic [3:0]       w_differ;
  logic [3:0]       w_expire;
  logic [3:0]       w_press;

  // A button commits its new level on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
  always_comb begin
    w_differ = r_btn_sync2 ^ r_btn_stable;
    w_expire = 4'h0;
    for (int k = 0; k < 4; k++) begin
      w_expire[k] = w_differ[k] && (r_cnt[k] == CNT_MAX);
    end
    w_press = w_expire & r_btn_sync2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_sync1   <= 4'h0;
      r_btn_sync2   <= 4'h0;
      r_sw_sync1    <= 16'h0000;
      r_sw_sync2    <= 16'h0000;
      r_btn_stable  <= 4'h0;
      r_press_pulse <= 4'h0;
      r_led         <= 16'h0000;
      for (int k = 0; k < 4; k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      r_btn_sync1   <= btn;
      r_btn_sync2   <= r_btn_sync1;
      r_sw_sync1    <= sw;
      r_sw_sync2    <= r_sw_sync1;
      r_press_pulse <= w_press;
      for (int k = 0; k < 4; k++) begin
        if (!w_differ[k] || w_expire[k]) begin
          r_cnt[k] <= '0;
        end else begin
          r_cnt[k] <= r_cnt[k] + CNT_W'(1);
        end
        if (w_expire[k]) begin
          r_btn_stable[k] <= r_btn_sync2[k];
        end
        if (w_press[k]) begin
          r_led[4*k +: 4] <= r_sw_sync2[4*k +: 4];
        end
      end
    end
  end

  assign led         = r_led;
  assign btn_stable  = r_btn_stable;
  assign press_pulse = r_press_pulse;

endmodule

// File: tb/tb_btn_debounce_latch.sv
// Bench for btn_debounce_latch: directed scenarios with literal expectations plus randomized
// bouncing buttons, all checked every cycle against a run-length behavioural model.
module tb_btn_debounce_latch;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  btn;
  logic [15:0] sw;
  logic [15:0] led;
  logic [3:0]  btn_stable;
  logic [3:0]  press_pulse;

  int checks = 0;
  int errors = 0;

  btn_debounce_latch #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .btn(btn), .sw(sw),
    .led(led), .btn_stable(btn_stable), .press_pulse(press_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: inputs reach the debouncer two edges late; a level is accepted after
  // D consecutive edges of disagreeing with the accepted level.
  logic [3:0]  bq[$];
  logic [15:0] sq[$];
  int          run[4];
  logic [3:0]  m_stable;
  logic [3:0]  m_pulse;
  logic [15:0] m_led;
  bit          mdl_ok = 1'b0;

  task automatic model_clear();
    bq.delete(); bq.push_back(4'h0); bq.push_back(4'h0);
    sq.delete(); sq.push_back(16'h0); sq.push_back(16'h0);
    for (int k = 0; k < 4; k++) run[k] = 0;
    m_stable = 4'h0;
    m_pulse  = 4'h0;
    m_led    = 16'h0;
  endtask

  task automatic model_step();
    logic [3:0]  s2;
    logic [15:0] w2;
    if (rst) begin
      model_clear();
    end else begin
      s2 = bq.pop_back(); bq.push_front(btn);
      w2 = sq.pop_back(); sq.push_front(sw);
      m_pulse = 4'h0;
      for (int k = 0; k < 4; k++) begin
        if (s2[k] != m_stable[k]) begin
          run[k]++;
          if (run[k] == D) begin
            run[k] = 0;
            m_stable[k] = s2[k];
            if (s2[k]) begin
              m_pulse[k] = 1'b1;
              m_led[4*k +: 4] = w2[4*k +: 4];
            end
          end
        end else begin
          run[k] = 0;
        end
      end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      model_step();
      mdl_ok = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mdl_ok) begin
        check("led_vs_model", 32'(led), 32'(m_led));
        check("stable_vs_model", 32'(btn_stable), 32'(m_stable));
        check("pulse_vs_model", 32'(press_pulse), 32'(m_pulse));
      end
    end
  end

  int         npulse;
  logic [3:0] last_pulse;
  int         hold[4];
  logic [3:0] rb;

  initial begin
    rst = 1'b1;
    btn = 4'($urandom);
    sw  = 16'($urandom);
    tick(2);
    check("reset_led", 32'(led), 32'h0);
    check("reset_stable", 32'(btn_stable), 32'h0);
    check("reset_pulse", 32'(press_pulse), 32'h0);

    // Two buttons held from edge 1: accepted on edge D+2.
    rst = 1'b0; btn = 4'b0011; sw = 16'h5555;
    tick(5);
    check("latency_stable_e5", 32'(btn_stable), 32'h0);
    check("latency_pulse_e5", 32'(press_pulse), 32'h0);
    tick(1);
    check("press_stable_e6", 32'(btn_stable), 32'h3);
    check("press_pulse_e6", 32'(press_pulse), 32'h3);
    check("press_led_e6", 32'(led), 32'h0055);
    check("model_led_e6", 32'(m_led), 32'h0055);
    tick(1);
    check("pulse_once_e7", 32'(press_pulse), 32'h0);
    tick(13);
    check("led_hold_e20", 32'(led), 32'h0055);

    // Short glitch on btn[2] must be ignored.
    btn = 4'b0111; tick(3);
    btn = 4'b0011; tick(10);
    check("glitch_stable", 32'(btn_stable), 32'h3);
    check("glitch_led", 32'(led), 32'h0055);

    // Switch change while held does nothing; release and re-press loads new value.
    sw = 16'hAAAA; tick(10);
    check("held_sw_led", 32'(led), 32'h0055);
    btn = 4'b0010; tick(8);
    check("release_stable", 32'(btn_stable), 32'h2);
    check("release_led", 32'(led), 32'h0055);
    btn = 4'b0011; tick(8);
    check("repress_led", 32'(led), 32'h005A);

    // Simultaneous press of all four.
    btn = 4'b0000; tick(8);
    sw = 16'h5555; btn = 4'b1111;
    npulse = 0; last_pulse = 4'h0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (press_pulse != 4'h0) begin npulse++; last_pulse = press_pulse; end
    end
    check("all_pulse_count", 32'(npulse), 32'd1);
    check("all_pulse_value", 32'(last_pulse), 32'hF);
    check("all_led", 32'(led), 32'h5555);

    // Reset mid-count discards progress.
    btn = 4'b0000; tick(8);
    btn = 4'b0010; tick(2);
    rst = 1'b1; tick(2);
    check("midrst_led", 32'(led), 32'h0);
    check("midrst_stable", 32'(btn_stable), 32'h0);
    check("midrst_pulse", 32'(press_pulse), 32'h0);
    rst = 1'b0;
    tick(5);
    check("postrst_stable_e5", 32'(btn_stable), 32'h0);
    tick(1);
    check("postrst_stable_e6", 32'(btn_stable), 32'h2);
    check("postrst_pulse_e6", 32'(press_pulse), 32'h2);
    check("postrst_led_e6", 32'(led), 32'h0050);

    // Randomized bouncing buttons, switch changes and occasional reset.
    rb = btn;
    for (int k = 0; k < 4; k++) hold[k] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < 4; k++) begin
        if (hold[k] == 0) begin
          rb[k] = 1'($urandom_range(0, 1));
          hold[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 10);
        end
        hold[k]--;
      end
      btn = rb;
      if ($urandom_range(0, 15) == 0) sw = 16'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      tick(1);
    end

    rst = 1'b0;
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_debounce_latch.md
BTN_DEBOUNCE_LATCH -- requirements
Module: btn_debounce_latch

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, SHALL set the debounce hold time in clk cycles; legal range is >= 2.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous and active-high.
REQ-004 btn  input  4  SHALL carry raw, asynchronous, bouncing push-buttons; btn[k] owns switch group k.
REQ-005 sw  input  16  SHALL carry raw, asynchronous slide switches; group k is sw[4k+3:4k].
REQ-006 led  output  16  SHALL be the registered LED drive; group k is led[4k+3:4k].
REQ-007 btn_stable  output  4  SHALL be the registered debounced level of each button.
REQ-008 press_pulse  output  4  SHALL be a registered one-cycle strobe per debounced press.

Function
REQ-009 Each btn and sw bit SHALL pass through a 2-flop synchronizer (sync1, then sync2); only sync2 values are used downstream.
REQ-010 Each button SHALL own an independent counter of width clog2(DEBOUNCE_CYCLES).
REQ-011 Per button, each edge: if sync2 == btn_stable, counter <= 0.
REQ-012 Per button, each edge: if sync2 != btn_stable and counter < DEBOUNCE_CYCLES-1, counter <= counter+1.
REQ-013 Per button, each edge: if sync2 != btn_stable and counter == DEBOUNCE_CYCLES-1, btn_stable <= sync2 and counter <= 0.
REQ-014 Latency: raw btn held constant from edge 1 SHALL update btn_stable at edge DEBOUNCE_CYCLES+2, never earlier.
REQ-015 A raw level lasting fewer than DEBOUNCE_CYCLES sync2 cycles SHALL not change btn_stable, press_pulse or led; its counter restarts from 0.
REQ-016 On the edge where btn_stable[k] goes 0->1, press_pulse[k] SHALL be 1 for exactly that cycle; otherwise 0.
REQ-017 A debounced release (1->0) SHALL update btn_stable only; no pulse, no led change.
REQ-018 On the same edge press_pulse[k] rises, led group k SHALL load sync2 of switch group k; the other groups hold.
REQ-019 Simultaneous presses SHALL load all pressed groups on the same edge, each from its own switch group.
REQ-020 Switch changes without a press SHALL never alter led; held buttons SHALL not re-trigger.
REQ-021 Debounce, pulse and latch logic SHALL contain no combinational path from input to output.

Reset
REQ-022 While rst=1 at an edge: led=16'h0000, btn_stable=4'h0, press_pulse=4'h0, and all counters and synchronizer flops SHALL be 0.
REQ-023 Reset mid-count or mid-press SHALL discard progress; after release a button needs a full DEBOUNCE_CYCLES again.
REQ-024 rst SHALL take priority over every other update in the same cycle.

Verification (DEBOUNCE_CYCLES=4)
REQ-025 Reset: rst=1 for 2 edges with random btn/sw -> led=0000, btn_stable=0, press_pulse=0.
REQ-026 sw=16'h5555, btn=4'b0011 held from edge 1 -> at edge 6 btn_stable=0011 and press_pulse=0011 for one cycle; at edge 6 led=16'h0055; led stays 0055 through edge 20.
REQ-027 Glitch: btn[2] high for 3 cycles, then low -> btn_stable, press_pulse and led unchanged.
REQ-028 Hold btn[0], then change sw to 16'hAAAA -> led unchanged and no second pulse; release plus re-press (4+ cycles each) -> led[3:0]=4'hA.
REQ-029 btn=4'b1111, sw=16'h5555 -> single press_pulse=1111 on one edge, led=16'h5555; rst asserted 2 cycles after a btn[1] press starts -> no pulse, all outputs 0.
